neighbor_edge_scanner: RTL and testbench
========================================

NEIGHBOR_EDGE_SCANNER -- requirements
Module: neighbor_edge_scanner

Interface
REQ-001 SHALL have parameter NUM_PIX, default 12000: sensor pixel count and the address bound.
REQ-002 SHALL have parameter AW, default $clog2(12000)+2: signed neighbor-address width.
REQ-003 SHALL have parameter NODE_W, default 16: node-id width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output edge FIFO depth, power of 2, minimum 4.
REQ-005 SHALL have one clock and an asynchronous active-low reset: `clk` (input, 1) and `rstn` (input, 1).
REQ-006 SHALL have `in_valid` (input, 1): the neighbor set is offered.
REQ-007 SHALL have `in_ready` (output, 1): the block is able to capture a new neighbor set.
REQ-008 SHALL have `neighbor_pixels` (input, signed [AW-1:0] x 25): 5x5 window addresses in row-major order, with index 12 at the center.
REQ-009 SHALL have `src_node_id` (input, NODE_W): id of the new event node.
REQ-010 SHALL have `mem_rd_en` (output, 1): pixel-map read strobe.
REQ-011 SHALL have `mem_rd_addr` (output, AW-1): pixel-map address.
REQ-012 SHALL have `mem_rd_data` (input, NODE_W+1): {occupied, node_id}, valid exactly 1 cycle after `mem_rd_en`.
REQ-013 SHALL have `edge_valid` (output, 1), `edge_ready` (input, 1), `edge_src` (output, NODE_W) and `edge_dst` (output, NODE_W): the edge stream.
REQ-014 SHALL have `done` (output, 1): 1-cycle pulse marking the end of a scan.

Function
REQ-015 SHALL implement the states IDLE, SCAN and DRAIN; `in_ready` SHALL be 1 only in IDLE.
REQ-016 In IDLE, on in_valid&in_ready, SHALL capture all 25 addresses and src_node_id, set idx=0 and go to SCAN.
REQ-017 In SCAN, an entry SHALL count as invalid when its value is negative or >= NUM_PIX; an invalid entry SHALL be skipped in one cycle with no read.
REQ-018 In SCAN, for a valid entry, SHALL assert mem_rd_en combinationally with mem_rd_addr=entry[AW-2:0] and advance idx, but only if fifo_count+inflight < FIFO_DEPTH; otherwise SHALL hold idx.
REQ-019 On the cycle after a read, if the occupied bit is 1, SHALL push {src_node_id, node_id} into the FIFO; if the occupied bit is 0, SHALL drop the result.
REQ-020 SHALL go to DRAIN when idx advances past 24.
REQ-021 In DRAIN, when inflight==0 and the FIFO is empty, SHALL pulse done for 1 cycle and return to IDLE.
REQ-022 edge_valid SHALL equal FIFO non-empty; a pop SHALL occur on edge_valid&edge_ready; edge_src/edge_dst SHALL hold stable while edge_valid&!edge_ready.
REQ-023 When push and pop occur in the same cycle on a full FIFO, SHALL be legal because the credit rule in REQ-018 prevents overflow.
REQ-024 Latency: for a handshake in cycle T with entry 0 valid, SHALL put mem_rd_en in T+1 and edge_valid in T+3.
REQ-025 With edge_ready held 1, SHALL sustain one read per cycle (no credit stall).
REQ-026 Edges SHALL be emitted in ascending window index order.

Reset
REQ-027 On rstn=0, SHALL asynchronously enter IDLE and clear idx, inflight, the FIFO pointers and FIFO count.
REQ-028 Outputs during reset SHALL be: in_ready=1, mem_rd_en=0, edge_valid=0, done=0, and mem_rd_addr/edge_src/edge_dst=0.
REQ-029 A reset mid-scan SHALL discard the captured set and any buffered edges; a read return in the first cycle after release SHALL be ignored.

Configuration
REQ-030 With macro NEIGHBOR_SKIP_CENTER_EN defined, index 12 SHALL always be treated as invalid (no self-edge).
REQ-031 With NEIGHBOR_SKIP_CENTER_EN undefined, index 12 SHALL be processed like any other entry.

Verification
REQ-032 Interior pixel, all 25 addresses valid, memory all occupied, edge_ready=1, macro undefined -> 25 edges in index order, first edge_valid at T+3, done at T+28.
REQ-033 Same stimulus as REQ-032 with NEIGHBOR_SKIP_CENTER_EN defined -> 24 edges, none from entry 12.
REQ-034 Corner pixel (x=0,y=0): 16 entries = -1 and 9 valid, memory occupied only at the 9 valid addresses -> exactly 9 reads, 9 edges, 16 skip cycles, no read at a negative address.
REQ-035 All entries valid, memory occupied bit 0 everywhere -> 25 reads, 0 edges, done asserted.
REQ-036 edge_ready=0 for 20 cycles -> exactly FIFO_DEPTH (4) reads issued, then mem_rd_en stays 0; after release all 25 edges arrive with none lost or duplicated.
REQ-037 rstn pulsed low at SCAN idx=10 -> in_ready=1 and edge_valid=0 immediately; the next scan produces only its own edges.

Source files
------------

// File: rtl/neighbor_edge_scanner.sv
// neighbor_edge_scanner
//
// Walks a captured 5x5 neighbourhood of pixel-map addresses, reads the
// pixel map for each in-range entry and emits an edge {src, dst} for every
// occupied neighbour through a small output FIFO. Reads are issued only when
// the FIFO is guaranteed to have room for the result, so the FIFO never
// overflows even with the downstream stalled.
//
// Optional feature macro: NEIGHBOR_SKIP_CENTER_EN
//   defined   -> window index 12 (the event pixel itself) is never read
//   undefined -> index 12 is treated like every other entry
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a neighbour set; in_ready high
// SCAN  | stepping idx 0..24, one entry per cycle unless credit-stalled
// DRAIN | all entries issued; waiting for last read and empty FIFO
//
module neighbor_edge_scanner #(
    parameter int NUM_PIX    = 12000,
    parameter int AW         = $clog2(12000) + 2,
    parameter int NODE_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [AW-1:0] neighbor_pixels [0:24],
    input  logic [NODE_W-1:0]    src_node_id,
    output logic                 mem_rd_en,
    output logic [AW-2:0]        mem_rd_addr,
    input  logic [NODE_W:0]      mem_rd_data,
    output logic                 edge_valid,
    input  logic                 edge_ready,
    output logic [NODE_W-1:0]    edge_src,
    output logic [NODE_W-1:0]    edge_dst,
    output logic                 done
);

    localparam int            PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW        = PW + 1;
    localparam logic [AW-1:0] NUM_PIX_A = AW'(NUM_PIX);
    localparam logic [4:0]    LAST_IDX  = 5'd24;
    localparam logic [4:0]    CENTER    = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  win_q [0:24];
    logic signed [AW-1:0]  win_d [0:24];
    logic [NODE_W-1:0]     src_q, src_d;
    logic [4:0]            idx_q, idx_d;
    logic                  inflight_q, inflight_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [2*NODE_W-1:0]   fifo_q [0:FIFO_DEPTH-1];
    logic [2*NODE_W-1:0]   fifo_d [0:FIFO_DEPTH-1];

    logic [AW-1:0]         cur_entry;
    logic                  center_skip;
    logic                  entry_ok;
    logic [CW:0]           credit_used;
    logic                  credit_ok;
    logic                  capture;
    logic                  scan_step;
    logic                  push;
    logic                  pop;

    // Classify the entry under idx and decide whether a read may be issued.
    // A read is charged against FIFO space from issue until its result
    // lands, so count plus the in-flight read must stay below the depth.
    always_comb begin
        cur_entry = '0;
        if (idx_q <= LAST_IDX) begin
            cur_entry = win_q[idx_q];
        end
`ifdef NEIGHBOR_SKIP_CENTER_EN
        center_skip = (idx_q == CENTER);
`else
        center_skip = 1'b0;
`endif
        entry_ok    = !cur_entry[AW-1] && (cur_entry < NUM_PIX_A) && !center_skip;
        credit_used = (CW+1)'(count_q) + (CW+1)'(inflight_q);
        credit_ok   = credit_used < (CW+1)'(FIFO_DEPTH);
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_step && (idx_q == LAST_IDX)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, read strobe/address and end-of-scan pulse.
    always_comb begin
        in_ready    = (state_q == ST_IDLE);
        capture     = in_ready && in_valid;
        mem_rd_en   = (state_q == ST_SCAN) && entry_ok && credit_ok;
        mem_rd_addr = mem_rd_en ? cur_entry[AW-2:0] : '0;
        scan_step   = (state_q == ST_SCAN) && (!entry_ok || credit_ok);
        done        = (state_q == ST_DRAIN) && !inflight_q && (count_q == '0);
    end

    // Window capture, scan index and in-flight read tracking.
    always_comb begin
        win_d      = win_q;
        src_d      = src_q;
        idx_d      = idx_q;
        inflight_d = mem_rd_en;
        if (capture) begin
            win_d = neighbor_pixels;
            src_d = src_node_id;
            idx_d = '0;
        end else if (scan_step) begin
            idx_d = idx_q + 5'd1;
        end
    end

    // Scan datapath registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 25; i++) begin
                win_q[i] <= '0;
            end
            src_q      <= '0;
            idx_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            win_q      <= win_d;
            src_q      <= src_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
        end
    end

    // FIFO read side; data is forced to zero while empty so the outputs
    // are clean in reset and between scans.
    always_comb begin
        edge_valid = (count_q != '0);
        edge_src   = edge_valid ? fifo_q[rd_ptr_q][2*NODE_W-1:NODE_W] : '0;
        edge_dst   = edge_valid ? fifo_q[rd_ptr_q][NODE_W-1:0] : '0;
    end

    // FIFO write/pop bookkeeping. Read results only matter when a read was
    // actually issued last cycle; anything else on mem_rd_data is ignored.
    always_comb begin
        push     = inflight_q && mem_rd_data[NODE_W];
        pop      = edge_valid && edge_ready;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {src_q, mem_rd_data[NODE_W-1:0]};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_neighbor_edge_scanner.sv
// Bench for neighbor_edge_scanner: window/occupancy model, pixel-map
// responder and a negedge monitor comparing reads and edges to the model.
module tb_neighbor_edge_scanner;

    localparam int NUM_PIX = 12000;
    localparam int AW      = 16;
    localparam int NODE_W  = 16;
    localparam int IMG_W   = 120;
`ifdef NEIGHBOR_SKIP_CENTER_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [AW-1:0] np [0:24];
    logic [NODE_W-1:0]    src_node_id;
    logic                 mem_rd_en;
    logic [AW-2:0]        mem_rd_addr;
    logic [NODE_W:0]      mem_rd_data;
    logic                 edge_valid;
    logic                 edge_ready;
    logic [NODE_W-1:0]    edge_src;
    logic [NODE_W-1:0]    edge_dst;
    logic                 done;

    neighbor_edge_scanner dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .neighbor_pixels(np), .src_node_id(src_node_id),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_src(edge_src), .edge_dst(edge_dst), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Pixel-map model: occupancy by mode, node id derived from address.
    int occ_mode = 0;
    bit occ_set [int];

    function automatic logic [NODE_W-1:0] node_of(input int a);
        return NODE_W'(a * 3 + 7);
    endfunction

    function automatic bit occ_of(input int a);
        case (occ_mode)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return occ_set.exists(a);
            3:       return (a % 2) == 1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected read addresses and edges for the current scan.
    int      exp_rd_q [$];
    longint  exp_edge_q [$];

    task automatic build_model(input logic [NODE_W-1:0] src);
        exp_rd_q.delete();
        exp_edge_q.delete();
        for (int i = 0; i < 25; i++) begin
            int a;
            a = int'(np[i]);
            if (a >= 0 && a < NUM_PIX && !(SKIP && i == 12)) begin
                exp_rd_q.push_back(a);
                if (occ_of(a)) exp_edge_q.push_back(longint'({src, node_of(a)}));
            end
        end
    endtask

    task automatic fill_window(input int x, input int y, input bit clip);
        for (int dy = -2; dy <= 2; dy++) begin
            for (int dx = -2; dx <= 2; dx++) begin
                if (clip && (x + dx < 0 || y + dy < 0))
                    np[(dy + 2) * 5 + dx + 2] = -16'sd1;
                else
                    np[(dy + 2) * 5 + dx + 2] = AW'((y + dy) * IMG_W + (x + dx));
            end
        end
    endtask

    // Memory responder: data valid the cycle after a read; when no read was
    // issued it presents an occupied garbage word that must be ignored.
    bit            pend = 1'b0;
    int            pend_addr = 0;
    always @(negedge clk) begin
        pend      = mem_rd_en;
        pend_addr = int'(mem_rd_addr);
    end
    always @(posedge clk) begin
        #1;
        mem_rd_data = pend ? {occ_of(pend_addr), node_of(pend_addr)} : {1'b1, 16'hDEAD};
    end

    // Monitor / compare process.
    int      ncyc = 0;
    int      t_hs = 0;
    bit      timing_chk = 1'b0;
    bit      first_rd_pend = 1'b0;
    bit      first_ev_pend = 1'b0;
    bit      first_pop_pend = 1'b0;
    int      first_dst = -1;
    int      rd_seen = 0;
    int      edges_seen = 0;
    int      done_cnt = 0;
    bit      prev_stall = 1'b0;
    longint  prev_edge = 0;

    always @(negedge clk) begin
        ncyc++;
        if (rstn) begin
            if (in_valid && in_ready) begin
                t_hs           = ncyc;
                first_rd_pend  = 1'b1;
                first_ev_pend  = 1'b1;
                first_pop_pend = 1'b1;
            end
            if (mem_rd_en) begin
                rd_seen++;
                if (timing_chk && first_rd_pend) chk("rd_latency", ncyc - t_hs, 1);
                first_rd_pend = 1'b0;
                if (exp_rd_q.size() == 0) chk("rd_unexpected", int'(mem_rd_addr), -1);
                else chk("rd_addr", int'(mem_rd_addr), exp_rd_q.pop_front());
            end
            if (edge_valid && first_ev_pend) begin
                if (timing_chk) chk("edge_latency", ncyc - t_hs, 3);
                first_ev_pend = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", edge_valid, 1);
                chk("stall_hold", longint'({edge_src, edge_dst}), prev_edge);
            end
            if (edge_valid && edge_ready) begin
                edges_seen++;
                if (first_pop_pend) begin
                    first_dst      = int'(edge_dst);
                    first_pop_pend = 1'b0;
                end
                if (exp_edge_q.size() == 0) chk("edge_extra", longint'({edge_src, edge_dst}), -1);
                else chk("edge", longint'({edge_src, edge_dst}), exp_edge_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (timing_chk) chk("done_latency", ncyc - t_hs, 28);
                chk("done_rd_left", exp_rd_q.size(), 0);
                chk("done_edge_left", exp_edge_q.size(), 0);
            end
            prev_stall = edge_valid && !edge_ready;
            prev_edge  = longint'({edge_src, edge_dst});
        end else begin
            prev_stall = 1'b0;
        end
    end

    int rd_base, ed_base, dn_base;

    task automatic handshake(input logic [NODE_W-1:0] src);
        rd_base = rd_seen;
        ed_base = edges_seen;
        dn_base = done_cnt;
        @(posedge clk); #1;
        src_node_id = src;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == dn_base && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", done_cnt - dn_base, 1);
    endtask

    task automatic run_scan(input logic [NODE_W-1:0] src, input bit tchk,
                            input int exp_rd, input int exp_ed);
        build_model(src);
        timing_chk = tchk;
        handshake(src);
        wait_done(300);
        chk("reads", rd_seen - rd_base, exp_rd);
        chk("edges", edges_seen - ed_base, exp_ed);
    endtask

    int bvec [0:24] = '{12000, 11999, 0, -1, -32768, 32767, 1, 11998, 5, 7,
                        12001, -2, 100, 101, 3333, 4444, 9, 11, 13, 15,
                        16383, 16384, 17, 19, 21};

    initial begin
        rstn        = 1'b1;
        in_valid    = 1'b0;
        edge_ready  = 1'b1;
        src_node_id = '0;
        for (int i = 0; i < 25; i++) np[i] = '0;
        #2 rstn = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_edge_valid", edge_valid, 0);
        chk("rst_edge_src", edge_src, 0);
        chk("rst_edge_dst", edge_dst, 0);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Interior pixel, everything occupied, full-rate streaming.
        occ_mode = 0;
        fill_window(10, 10, 1'b0);
        run_scan(16'h0100, 1'b1, SKIP ? 24 : 25, SKIP ? 24 : 25);
        chk("first_dst", first_dst, 2911);

        // Top-left corner: 16 entries are -1, only the 9 in-image ones read.
        occ_mode = 2;
        occ_set.delete();
        foreach (np[i]) ;
        fill_window(0, 0, 1'b1);
        for (int i = 0; i < 25; i++) if (np[i] >= 0) occ_set[int'(np[i])] = 1'b1;
        run_scan(16'h0200, 1'b0, SKIP ? 8 : 9, SKIP ? 8 : 9);

        // Nothing occupied: reads happen, no edges, done still pulses.
        occ_mode = 1;
        fill_window(30, 40, 1'b0);
        run_scan(16'h0300, 1'b0, SKIP ? 24 : 25, 0);

        // Range boundaries: 11999 valid, 12000 / negative / large invalid.
        occ_mode = 3;
        for (int i = 0; i < 25; i++) np[i] = AW'(bvec[i]);
        run_scan(16'h0400, 1'b0, SKIP ? 16 : 17, 13);

        // Downstream stalled for 20 cycles: only FIFO_DEPTH reads allowed.
        occ_mode = 0;
        fill_window(20, 30, 1'b0);
        build_model(16'h0500);
        timing_chk = 1'b0;
        @(posedge clk); #1 edge_ready = 1'b0;
        handshake(16'h0500);
        repeat (20) @(posedge clk);
        chk("bp_reads", rd_seen - rd_base, 4);
        chk("bp_edges", edges_seen - ed_base, 0);
        #1 edge_ready = 1'b1;
        wait_done(300);
        chk("bp_total_reads", rd_seen - rd_base, SKIP ? 24 : 25);
        chk("bp_total_edges", edges_seen - ed_base, SKIP ? 24 : 25);

        // Reset in the middle of a scan at idx 10.
        fill_window(50, 50, 1'b0);
        build_model(16'h0600);
        timing_chk = 1'b0;
        handshake(16'h0600);
        begin
            int n;
            n = 0;
            while (rd_seen - rd_base < 10 && n < 100) begin
                @(posedge clk);
                n++;
            end
            chk("mid_reads", rd_seen - rd_base, 10);
        end
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_edge_valid", edge_valid, 0);
        chk("mid_rst_rd_en", mem_rd_en, 0);
        exp_rd_q.delete();
        exp_edge_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        occ_mode = 2;
        occ_set.delete();
        fill_window(0, 0, 1'b1);
        for (int i = 0; i < 25; i++) if (np[i] >= 0) occ_set[int'(np[i])] = 1'b1;
        run_scan(16'h0700, 1'b0, SKIP ? 8 : 9, SKIP ? 8 : 9);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
